// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample strobe, bit strobe and a square baud clock.
// Optional BAUD_CUSTOM_DIV_EN adds a runtime divisor override (use_custom/custom_div).
module baud_gen_frac #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int OVERSAMPLE = 16,
   parameter int FRAC_BITS  = 4,
   parameter int DIV_W      = 20,
   parameter int BAUD0      = 2400,
   parameter int BAUD1      = 4800,
   parameter int BAUD2      = 9600,
   parameter int BAUD3      = 19200
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       baud_rate,
`ifdef BAUD_CUSTOM_DIV_EN
   input  logic             use_custom,
   input  logic [DIV_W-1:0] custom_div,
`endif
   output logic             rx_tick,
   output logic             tx_tick,
   output logic             baud_clk
);
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int INT_W = DIV_W - FRAC_BITS;
   localparam int CNT_W = INT_W + 1;

   function automatic longint calc_div(input longint baud);
      longint den;
      den = baud * longint'(OVERSAMPLE);
      return (longint'(CLOCK_FREQ) * (longint'(1) << FRAC_BITS) + den / 2) / den;
   endfunction

   function automatic bit div_ok(input longint div);
      return ((div >> FRAC_BITS) >= 2) && (div < (longint'(1) << DIV_W));
   endfunction

   localparam longint DIV0 = calc_div(longint'(BAUD0));
   localparam longint DIV1 = calc_div(longint'(BAUD1));
   localparam longint DIV2 = calc_div(longint'(BAUD2));
   localparam longint DIV3 = calc_div(longint'(BAUD3));

   localparam logic [DIV_W-1:0] DIV0_V = DIV_W'(DIV0);
   localparam logic [DIV_W-1:0] DIV1_V = DIV_W'(DIV1);
   localparam logic [DIV_W-1:0] DIV2_V = DIV_W'(DIV2);
   localparam logic [DIV_W-1:0] DIV3_V = DIV_W'(DIV3);

   if (!(div_ok(DIV0) && div_ok(DIV1) && div_ok(DIV2) && div_ok(DIV3)) ||
       (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_cfg
      $error("baud_gen_frac: divisor integer part < 2, divisor wider than DIV_W, or bad OVERSAMPLE");
   end

   logic [CNT_W-1:0]     r_div_cnt;
   logic [FRAC_BITS-1:0] r_acc;
   logic [OS_W-1:0]      r_os_cnt;
   logic [1:0]           r_rate_q;
   logic                 r_rx_tick;
   logic                 r_tx_tick;
   logic                 r_baud_clk;
`ifdef BAUD_CUSTOM_DIV_EN
   logic                 r_use_q;
   logic [DIV_W-1:0]     r_cdiv_q;
`endif

   logic [DIV_W-1:0]     w_div;
   logic [INT_W-1:0]     w_div_int;
   logic [FRAC_BITS:0]   w_acc_sum;
   logic [CNT_W-1:0]     w_len;
   logic                 w_restart;
   logic                 w_os_wrap;
   logic [OS_W-1:0]      w_os_next;

   always_comb begin
      case (r_rate_q)
         2'b00:   w_div = DIV0_V;
         2'b01:   w_div = DIV1_V;
         2'b10:   w_div = DIV2_V;
         default: w_div = DIV3_V;
      endcase
      w_restart = (baud_rate != r_rate_q);
`ifdef BAUD_CUSTOM_DIV_EN
      if (r_use_q) begin
         if (r_cdiv_q[DIV_W-1:FRAC_BITS] < INT_W'(2)) w_div = {INT_W'(2), FRAC_BITS'(0)};
         else                                         w_div = r_cdiv_q;
      end
      if ((use_custom != r_use_q) || (use_custom && (custom_div != r_cdiv_q))) w_restart = 1'b1;
`endif
      w_div_int = w_div[DIV_W-1:FRAC_BITS];
      // carry out of the fractional accumulator stretches this period by one clock
      w_acc_sum = {1'b0, r_acc} + {1'b0, w_div[FRAC_BITS-1:0]};
      w_len     = {1'b0, w_div_int} + CNT_W'(w_acc_sum[FRAC_BITS]);
      w_os_wrap = (r_os_cnt == OS_W'(OVERSAMPLE - 1));
      w_os_next = w_os_wrap ? '0 : r_os_cnt + OS_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset || !enable) begin
         r_div_cnt  <= '0;
         r_acc      <= '0;
         r_os_cnt   <= '0;
         r_rate_q   <= '0;
         r_rx_tick  <= 1'b0;
         r_tx_tick  <= 1'b0;
         r_baud_clk <= 1'b0;
`ifdef BAUD_CUSTOM_DIV_EN
         r_use_q    <= 1'b0;
         r_cdiv_q   <= '0;
`endif
      end else if (w_restart) begin
         r_div_cnt  <= '0;
         r_acc      <= '0;
         r_os_cnt   <= '0;
         r_rate_q   <= baud_rate;
         r_rx_tick  <= 1'b0;
         r_tx_tick  <= 1'b0;
         r_baud_clk <= 1'b0;
`ifdef BAUD_CUSTOM_DIV_EN
         r_use_q    <= use_custom;
         r_cdiv_q   <= custom_div;
`endif
      end else begin
         r_rx_tick <= 1'b0;
         r_tx_tick <= 1'b0;
         // a zero count means the cleared state: this edge opens the first period
         if (r_div_cnt == '0) begin
            r_div_cnt <= w_len - CNT_W'(1);
            r_acc     <= w_acc_sum[FRAC_BITS-1:0];
         end else if (r_div_cnt == CNT_W'(1)) begin
            r_div_cnt  <= w_len;
            r_acc      <= w_acc_sum[FRAC_BITS-1:0];
            r_rx_tick  <= 1'b1;
            r_tx_tick  <= w_os_wrap;
            r_os_cnt   <= w_os_next;
            r_baud_clk <= (w_os_next >= OS_W'(OVERSAMPLE / 2));
         end else begin
            r_div_cnt <= r_div_cnt - CNT_W'(1);
         end
      end
   end

   assign rx_tick  = r_rx_tick;
   assign tx_tick  = r_tx_tick;
   assign baud_clk = r_baud_clk;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac at 50 MHz with the default rate table.
module tb_baud_gen_frac;
   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        enable    = 1'b0;
   logic [1:0]  baud_rate = 2'b10;
`ifdef BAUD_CUSTOM_DIV_EN
   logic        use_custom = 1'b0;
   logic [19:0] custom_div = '0;
`endif
   logic        rx_tick;
   logic        tx_tick;
   logic        baud_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #10 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   baud_gen_frac dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .baud_rate  (baud_rate),
`ifdef BAUD_CUSTOM_DIV_EN
      .use_custom (use_custom),
      .custom_div (custom_div),
`endif
      .rx_tick    (rx_tick),
      .tx_tick    (tx_tick),
      .baud_clk   (baud_clk)
   );

   task automatic wait_rx(input int budget, output int t, output logic txv);
      t = -1; txv = 1'b0;
      for (int i = 0; i < budget && t < 0; i++) begin
         @(negedge clock);
         if (rx_tick === 1'b1) begin t = cyc; txv = tx_tick; end
      end
   endtask

   task automatic wait_tx(input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget && t < 0; i++) begin
         @(negedge clock);
         if (tx_tick === 1'b1) t = cyc;
      end
   endtask

   task automatic wait_bclk(input logic level, input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget && t < 0; i++) begin
         @(negedge clock);
         if (baud_clk === level) t = cyc;
      end
   endtask

   task automatic test_reset();
      baud_rate = 2'b10; enable = 1'b1; reset = 1'b1;
      repeat (5) @(negedge clock);
      n_cmp++;
      if ({rx_tick, tx_tick, baud_clk} !== 3'b000) begin
         n_bad++; $display("FAIL reset_outputs: got %b want 000", {rx_tick, tx_tick, baud_clk});
      end
   endtask

   task automatic test_rate_9600();
      int e0, t, prev, tx1, r1, f1, r2, exp_iv;
      logic txv;
      reset = 1'b0; e0 = cyc + 1;
      wait_rx(400, t, txv);
      n_cmp++;
      if (t != e0 + 325) begin n_bad++; $display("FAIL first_rx_9600: got %0d want %0d", t - e0, 325); end
      prev = t;
      for (int i = 1; i <= 5; i++) begin
         wait_rx(400, t, txv);
         exp_iv = (i % 2 == 1) ? 326 : 325;
         n_cmp++;
         if (t - prev != exp_iv) begin n_bad++; $display("FAIL rx_interval_9600[%0d]: got %0d want %0d", i, t - prev, exp_iv); end
         prev = t;
      end
      wait_tx(6000, tx1);
      n_cmp++;
      if (tx1 != e0 + 5208) begin n_bad++; $display("FAIL first_tx_9600: got %0d want 5208", tx1 - e0); end
      wait_bclk(1'b1, 6000, r1);
      n_cmp++;
      if (r1 != e0 + 7812) begin n_bad++; $display("FAIL bclk_rise_9600: got %0d want 7812", r1 - e0); end
      wait_bclk(1'b0, 6000, f1);
      n_cmp++;
      if (f1 - r1 != 2604) begin n_bad++; $display("FAIL bclk_high_9600: got %0d want 2604", f1 - r1); end
      n_cmp++;
      if (tx_tick !== 1'b1) begin n_bad++; $display("FAIL tx_at_bclk_fall: got %b want 1", tx_tick); end
      n_cmp++;
      if (f1 - tx1 != 5208) begin n_bad++; $display("FAIL tx_interval_9600: got %0d want 5208", f1 - tx1); end
      wait_bclk(1'b1, 6000, r2);
      n_cmp++;
      if (r2 - r1 != 5208) begin n_bad++; $display("FAIL bclk_period_9600: got %0d want 5208", r2 - r1); end
   endtask

   task automatic test_rate_2400();
      int start, prev, t, n_long, n_tx, tx_at;
      logic txv;
      baud_rate = 2'b00; start = cyc + 1; prev = start;
      for (int b = 0; b < 2; b++) begin
         n_long = 0; n_tx = 0; tx_at = 0;
         for (int i = 1; i <= 16; i++) begin
            wait_rx(1400, t, txv);
            if (t - prev == 1303) n_long++;
            if (txv) begin n_tx++; tx_at = i; end
            prev = t;
         end
         n_cmp++;
         if (n_long != 1) begin n_bad++; $display("FAIL long_periods_2400[%0d]: got %0d want 1", b, n_long); end
         n_cmp++;
         if (n_tx != 1 || tx_at != 16) begin n_bad++; $display("FAIL tx_position_2400[%0d]: got %0d ticks at %0d want 1 at 16", b, n_tx, tx_at); end
         n_cmp++;
         if (prev - start != 20833) begin n_bad++; $display("FAIL bit_period_2400[%0d]: got %0d want 20833", b, prev - start); end
         start = prev;
      end
   endtask

   task automatic test_rate_4800();
      int r0, t, prev;
      logic txv;
      baud_rate = 2'b01; r0 = cyc + 1;
      wait_rx(800, t, txv);
      n_cmp++;
      if (t != r0 + 651) begin n_bad++; $display("FAIL first_rx_4800: got %0d want 651", t - r0); end
      prev = t;
      wait_rx(800, t, txv);
      n_cmp++;
      if (t - prev != 651) begin n_bad++; $display("FAIL rx_interval_4800: got %0d want 651", t - prev); end
   endtask

   task automatic test_rate_switch();
      int t, r1, r2, tx1;
      logic txv;
      baud_rate = 2'b10;
      for (int i = 0; i < 10; i++) wait_rx(400, t, txv);
      repeat (100) @(negedge clock);
      n_cmp++;
      if (baud_clk !== 1'b1) begin n_bad++; $display("FAIL bclk_before_switch: got %b want 1", baud_clk); end
      baud_rate = 2'b11; r1 = cyc + 1;
      @(negedge clock);
      n_cmp++;
      if ({rx_tick, tx_tick, baud_clk} !== 3'b000) begin
         n_bad++; $display("FAIL switch_cycle: got %b want 000", {rx_tick, tx_tick, baud_clk});
      end
      wait_rx(400, t, txv);
      n_cmp++;
      if (t != r1 + 162) begin n_bad++; $display("FAIL first_rx_19200: got %0d want 162", t - r1); end
      wait_tx(3000, tx1);
      n_cmp++;
      if (tx1 != r1 + 2604) begin n_bad++; $display("FAIL first_tx_19200: got %0d want 2604", tx1 - r1); end
      while (cyc < r1 + 2604 + 161) @(negedge clock);
      baud_rate = 2'b10; r2 = cyc + 1;
      @(negedge clock);
      n_cmp++;
      if (rx_tick !== 1'b0) begin n_bad++; $display("FAIL collide_no_tick: got %b want 0", rx_tick); end
      wait_rx(400, t, txv);
      n_cmp++;
      if (t != r2 + 325) begin n_bad++; $display("FAIL rx_after_collide: got %0d want 325", t - r2); end
   endtask

   task automatic test_reset_mid();
      int t, e0, tx1;
      logic txv;
      t = 0;
      for (int i = 0; i < 20 && baud_clk !== 1'b1; i++) wait_rx(400, t, txv);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({rx_tick, tx_tick, baud_clk} !== 3'b000) begin
         n_bad++; $display("FAIL async_reset_outputs: got %b want 000", {rx_tick, tx_tick, baud_clk});
      end
      @(negedge clock);
      reset = 1'b0; e0 = cyc + 1;
      wait_rx(400, t, txv);
      n_cmp++;
      if (t != e0 + 325) begin n_bad++; $display("FAIL rx_after_reset: got %0d want 325", t - e0); end
      wait_tx(6000, tx1);
      n_cmp++;
      if (tx1 != e0 + 5208) begin n_bad++; $display("FAIL tx_after_reset: got %0d want 5208", tx1 - e0); end
   endtask

   task automatic test_enable_drop();
      int t, e0, tx1, n_nz;
      logic txv;
      t = 0;
      for (int i = 0; i < 20 && baud_clk !== 1'b1; i++) wait_rx(400, t, txv);
      enable = 1'b0; n_nz = 0;
      repeat (50) begin
         @(negedge clock);
         if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || baud_clk !== 1'b0) n_nz++;
      end
      n_cmp++;
      if (n_nz != 0) begin n_bad++; $display("FAIL enable_low_quiet: got %0d active samples want 0", n_nz); end
      enable = 1'b1; e0 = cyc + 1;
      wait_rx(400, t, txv);
      n_cmp++;
      if (t != e0 + 325) begin n_bad++; $display("FAIL rx_after_enable: got %0d want 325", t - e0); end
      wait_tx(6000, tx1);
      n_cmp++;
      if (tx1 != e0 + 5208) begin n_bad++; $display("FAIL tx_after_enable: got %0d want 5208", tx1 - e0); end
   endtask

`ifdef BAUD_CUSTOM_DIV_EN
   task automatic test_custom();
      int r0, t, prev, tx1, exp_iv;
      logic txv;
      use_custom = 1'b1; custom_div = 20'h00048; r0 = cyc + 1;
      wait_rx(20, t, txv);
      n_cmp++;
      if (t != r0 + 4) begin n_bad++; $display("FAIL first_rx_custom: got %0d want 4", t - r0); end
      prev = t;
      for (int i = 1; i <= 4; i++) begin
         wait_rx(20, t, txv);
         exp_iv = (i % 2 == 1) ? 5 : 4;
         n_cmp++;
         if (t - prev != exp_iv) begin n_bad++; $display("FAIL rx_interval_custom[%0d]: got %0d want %0d", i, t - prev, exp_iv); end
         prev = t;
      end
      wait_tx(100, tx1);
      n_cmp++;
      if (tx1 != r0 + 72) begin n_bad++; $display("FAIL tx_custom: got %0d want 72", tx1 - r0); end
      custom_div = 20'h00010; r0 = cyc + 1;
      wait_rx(20, t, txv);
      n_cmp++;
      if (t != r0 + 2) begin n_bad++; $display("FAIL first_rx_clamp: got %0d want 2", t - r0); end
      prev = t;
      for (int i = 1; i <= 3; i++) begin
         wait_rx(20, t, txv);
         n_cmp++;
         if (t - prev != 2) begin n_bad++; $display("FAIL rx_interval_clamp[%0d]: got %0d want 2", i, t - prev); end
         prev = t;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rate_9600();
      test_rate_2400();
      test_rate_4800();
      test_rate_switch();
      test_reset_mid();
      test_enable_drop();
`ifdef BAUD_CUSTOM_DIV_EN
      test_custom();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised fractional baud generator. It replaces the fixed-divider BaudGen as the shared timing source for UART-Tx and UART-Rx. From the system clock it produces an oversampled strobe (rx_tick) for the receiver, a 1x strobe (tx_tick) for the transmitter, and a square baud_clk for debug and legacy use. A fractional accumulator dithers each oversample period between DIV_INT and DIV_INT+1 clocks so that the average rate error stays below one part in 2^FRAC_BITS periods.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
OVERSAMPLE, 16, rx_tick strobes per bit; even, >= 4
FRAC_BITS, 4, fractional bits of the divisor
DIV_W, 20, total divisor width (integer plus fractional)
BAUD0, 2400, rate selected by baud_rate=2'b00
BAUD1, 4800, rate selected by baud_rate=2'b01
BAUD2, 9600, rate selected by baud_rate=2'b10
BAUD3, 19200, rate selected by baud_rate=2'b11

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run when high; when low, state is held cleared
baud_rate  in  2  rate select
rx_tick  out  1  one-cycle strobe, OVERSAMPLE per bit
tx_tick  out  1  one-cycle strobe, once per bit
baud_clk  out  1  square wave at the bit rate

Behaviour:
- Divisor: DIVn = round(CLOCK_FREQ*2^FRAC_BITS / (BAUDn*OVERSAMPLE)), computed at elaboration.
  - DIV_INT = DIVn >> FRAC_BITS; DIV_FRAC = the low FRAC_BITS bits.
  - Elaboration error if DIV_INT < 2 or DIVn does not fit in DIV_W.
- State registers: div_cnt, acc (FRAC_BITS wide), os_cnt (clog2(OVERSAMPLE) wide), rate_q (registered baud_rate).
- Reset value of all state and all outputs: 0.
- Period rule: each period starts with {carry, acc} = acc + DIV_FRAC. The period lasts DIV_INT+carry clocks.
- rx_tick is high for exactly the last cycle of each period, registered with no combinational path from the inputs.
- os_cnt increments on each rx_tick and wraps at OVERSAMPLE-1 -> 0.
- tx_tick is asserted together with the rx_tick on which os_cnt wraps OVERSAMPLE-1 -> 0.
- baud_clk = 1 while os_cnt >= OVERSAMPLE/2, otherwise 0. It is registered, so the duty cycle is within one oversample period of 50%.
- First period after reset release, after enable rising, or after a restart:
  - acc starts at 0.
  - First rx_tick is DIV_INT (+carry) clocks after the first active edge.
  - First tx_tick is at the OVERSAMPLE-th rx_tick.
- Restart: when baud_rate != rate_q, in that cycle:
  - div_cnt, acc and os_cnt are cleared; no tick is issued; rate_q is updated.
  - Timing then resumes as in the first-period rule.
- enable low: state is held cleared, rx_tick, tx_tick and baud_clk are 0. Each strobe is at most one cycle and never stretched.
- Reset asserted mid-period: outputs go to 0 immediately (asynchronous). No partial tick on release.
- Simultaneous rate change and period end: the restart wins and no tick is issued.
- 50 MHz examples:
  - 9600: DIV = 5208 (DIV_INT 325, DIV_FRAC 8). Periods alternate 325, 326, ... Bit period = 5208 clocks.
  - 2400: DIV = 20833 (DIV_INT 1302, DIV_FRAC 1). Bit period = 20833 clocks.

Optional Feature:
Macro BAUD_CUSTOM_DIV_EN.
- Defined:
  - Adds ports use_custom (in, 1) and custom_div (in, DIV_W), same fixed-point format as the table divisors.
  - When use_custom = 1, custom_div replaces the table divisor. An integer part < 2 is clamped to 2.0.
  - Any change of use_custom, or of custom_div while use_custom = 1, triggers a restart.
- Undefined:
  - Ports are absent. Only the table is used; behaviour is identical to the rules above.

Test Plan:
1. Reset high for 100 ns, release, enable=1, baud_rate=2'b10. Required:
   - rx_tick intervals 325, 326, 325, ...
   - First tx_tick 5208 clocks after release; subsequent tx_tick intervals exactly 5208 clocks.
   - baud_clk period 5208 clocks.
2. baud_rate=2'b00, run 4 bits. Required:
   - 16 rx_ticks per tx_tick.
   - tx_tick intervals 20833 clocks.
   - Exactly one 1303-clock period per 16 periods.
3. Switch 2'b10 -> 2'b11 mid-bit. Required:
   - No tick in the switch cycle.
   - os_cnt back to 0.
   - First new rx_tick after DIV_INT = 162 clocks (DIV 2604, DIV_FRAC 12).
4. Assert reset for 1 cycle mid-period. Required:
   - All outputs 0 immediately.
   - Timing identical to scenario 1 from release.
5. Drop enable for 50 cycles during run, then raise. Required:
   - No ticks while enable is low; baud_clk = 0.
   - Restart timing as in scenario 1 afterwards.
6. With BAUD_CUSTOM_DIV_EN defined: use_custom=1, custom_div=16'h0048 (4.5). Required:
   - rx_tick intervals 4, 5, 4, 5, ...
   - tx_tick every 72 clocks.
   - custom_div=0x0010 gives intervals of 2 clocks (clamped).
